// File: rtl/mem_readback_checker_pkg.sv
// Shared types and width constants for the memory readback checker.
package mem_readback_checker_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned POP_W      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_readback_checker_popcount64.sv
// Combinational population count of a 64-bit word as a balanced adder tree.
module mem_readback_checker_popcount64
    import mem_readback_checker_pkg::*;
(
    input  logic [DATA_W_DEF-1:0] data_i,
    output logic [POP_W-1:0]      count_c
);

    logic [1:0] s1 [32];
    logic [2:0] s2 [16];
    logic [3:0] s3 [8];
    logic [4:0] s4 [4];
    logic [5:0] s5 [2];

    // Each level widens by one bit, so no partial sum can overflow.
    always_comb begin
        for (int i = 0; i < 32; i++) s1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
        for (int i = 0; i < 16; i++) s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
        for (int i = 0; i < 8; i++)  s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
        for (int i = 0; i < 4; i++)  s4[i] = {1'b0, s3[2*i]} + {1'b0, s3[2*i+1]};
        for (int i = 0; i < 2; i++)  s5[i] = {1'b0, s4[2*i]} + {1'b0, s4[2*i+1]};
        count_c = {1'b0, s5[0]} + {1'b0, s5[1]};
    end

endmodule

// File: rtl/mem_readback_checker.sv
// Sweeps a read range, aligns returned data to its address through a latency
// pipe, and accumulates word/bit error statistics with first-failure capture.
module mem_readback_checker
    import mem_readback_checker_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic              R_EN,
    output logic [ADDR_W-1:0] R_ADDR,
    input  logic [DATA_W-1:0] real_data,
    input  logic [DATA_W-1:0] wrong_real_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_err_cnt,
    output logic [ADDR_W+6:0] bit_err_cnt,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_syn
);

    localparam int unsigned WCNT_W = ADDR_W + 1;
    localparam int unsigned BCNT_W = ADDR_W + POP_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   hi_q, hi_d;
    logic                r_en_q, r_en_d;
    logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                fev_q, fev_d;
    logic [ADDR_W-1:0]   fea_q, fea_d;
    logic [DATA_W-1:0]   fes_q, fes_d;
    logic [RD_LAT-1:0]   pipe_v_q, pipe_v_d;
    logic [ADDR_W-1:0]   pipe_a_q [RD_LAT];
    logic [ADDR_W-1:0]   pipe_a_d [RD_LAT];

    logic [DATA_W-1:0]   diff_c;
    logic [POP_W-1:0]    pop_c;
    logic [WCNT_W:0]     wsum_c;
    logic [BCNT_W:0]     bsum_c;

    assign diff_c = real_data ^ wrong_real_data;

    mem_readback_checker_popcount64 u_popcount (
        .data_i  (64'(diff_c)),
        .count_c (pop_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            r_en_q   <= 1'b0;
            r_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            fev_q    <= 1'b0;
            fea_q    <= '0;
            fes_q    <= '0;
            pipe_v_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_a_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            r_en_q   <= r_en_d;
            r_addr_q <= r_addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            fev_q    <= fev_d;
            fea_q    <= fea_d;
            fes_q    <= fes_d;
            pipe_v_q <= pipe_v_d;
            for (int i = 0; i < RD_LAT; i++) pipe_a_q[i] <= pipe_a_d[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        r_en_d   = 1'b0;
        r_addr_d = r_addr_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        fev_d    = fev_q;
        fea_d    = fea_q;
        fes_d    = fes_q;
        pipe_v_d = '0;
        for (int i = 0; i < RD_LAT; i++) pipe_a_d[i] = pipe_a_q[i];

        // Pipe entry i holds the read issued i+1 cycles ago.
        pipe_v_d[0] = r_en_q;
        pipe_a_d[0] = r_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_a_d[i] = pipe_a_q[i-1];
        end

        wsum_c = {1'b0, wcnt_q} + (WCNT_W+1)'(1);
        bsum_c = {1'b0, bcnt_q} + (BCNT_W+1)'(pop_c);

        if (pipe_v_q[RD_LAT-1]) begin
            bcnt_d = bsum_c[BCNT_W] ? '1 : bsum_c[BCNT_W-1:0];
            if (diff_c != '0) begin
                wcnt_d = wsum_c[WCNT_W] ? '1 : wsum_c[WCNT_W-1:0];
                if (!fev_q) begin
                    fev_d = 1'b1;
                    fea_d = pipe_a_q[RD_LAT-1];
                    fes_d = diff_c;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hi_d   = addr_hi;
                    wcnt_d = '0;
                    bcnt_d = '0;
                    fev_d  = 1'b0;
                    fea_d  = '0;
                    fes_d  = '0;
                    if (addr_lo > addr_hi) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        r_en_d   = 1'b1;
                        r_addr_d = addr_lo;
                        busy_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                busy_d = 1'b1;
                // Stop on the inclusive bound so hi = all-ones never wraps.
                if (r_addr_q == hi_q) begin
                    state_d = DRAIN;
                end else begin
                    r_en_d   = 1'b1;
                    r_addr_d = r_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (pipe_v_d == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign R_EN            = r_en_q;
    assign R_ADDR          = r_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign word_err_cnt    = wcnt_q;
    assign bit_err_cnt     = bcnt_q;
    assign first_err_valid = fev_q;
    assign first_err_addr  = fea_q;
    assign first_err_syn   = fes_q;

endmodule

// File: tb/tb_mem_readback_checker.sv
// Directed bench: two checkers (read latency 1 and 3) share stimulus, each fed
// by its own latency-matched memory model with an injectable corruption table.
module tb_mem_readback_checker;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic [AW-1:0] addr_lo, addr_hi;

    logic          r_en1, r_en3, busy1, busy3, done1, done3, fev1, fev3;
    logic [AW-1:0] r_addr1, r_addr3, fea1, fea3;
    logic [DW-1:0] rd1, wd1, rd3, wd3, fes1, fes3;
    logic [AW:0]   wcnt1, wcnt3;
    logic [AW+6:0] bcnt1, bcnt3;

    mem_readback_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .R_EN(r_en1), .R_ADDR(r_addr1), .real_data(rd1), .wrong_real_data(wd1),
        .busy(busy1), .done(done1), .word_err_cnt(wcnt1), .bit_err_cnt(bcnt1),
        .first_err_valid(fev1), .first_err_addr(fea1), .first_err_syn(fes1)
    );

    mem_readback_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .R_EN(r_en3), .R_ADDR(r_addr3), .real_data(rd3), .wrong_real_data(wd3),
        .busy(busy3), .done(done3), .word_err_cnt(wcnt3), .bit_err_cnt(bcnt3),
        .first_err_valid(fev3), .first_err_addr(fea3), .first_err_syn(fes3)
    );

    // Memory models: address delay lines of length 1 and 3 plus a corruption table.
    logic [DW-1:0] diff_mem [0:16383];
    logic [AW-1:0] sr1;
    logic [AW-1:0] sr3 [3];

    always @(posedge clk) begin
        sr1    <= r_addr1;
        sr3[0] <= r_addr3;
        sr3[1] <= sr3[0];
        sr3[2] <= sr3[1];
    end

    function automatic logic [DW-1:0] gold(input logic [AW-1:0] a);
        return 64'h5A5A_0000_F00D_0000 ^ {2'b00, a, 2'b00, a, 2'b00, a, 2'b00, a};
    endfunction

    assign rd1 = gold(sr1);
    assign wd1 = rd1 ^ diff_mem[sr1];
    assign rd3 = gold(sr3[2]);
    assign wd3 = rd3 ^ diff_mem[sr3[2]];

    // Cycle counter and negedge monitor of issue/done activity.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_done1, n_done3, n_ren1, n_ren3;
    int            done_cyc1, done_cyc3, iss_first1, iss_last1, iss_last3, start_cyc;
    logic [AW-1:0] q1 [$];

    always @(negedge clk) begin
        if (r_en1) begin
            if (n_ren1 == 0) iss_first1 = cyc;
            iss_last1 = cyc;
            n_ren1++;
            q1.push_back(r_addr1);
        end
        if (r_en3) begin
            iss_last3 = cyc;
            n_ren3++;
        end
        if (done1) begin
            n_done1++;
            done_cyc1 = cyc;
        end
        if (done3) begin
            n_done3++;
            done_cyc3 = cyc;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        n_done1 = 0; n_done3 = 0; n_ren1 = 0; n_ren3 = 0;
        done_cyc1 = 0; done_cyc3 = 0; iss_first1 = 0; iss_last1 = 0; iss_last3 = 0;
        q1.delete();
    endtask

    task automatic clear_diffs();
        for (int i = 0; i < 16384; i++) diff_mem[i] = '0;
    endtask

    task automatic sweep(input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        clear_mon();
        addr_lo   = lo;
        addr_hi   = hi;
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (n_done1 > 0 && n_done3 > 0) break;
            step();
        end
        chk({tag, "_done_seen"}, 64'(n_done1 > 0 && n_done3 > 0), 64'd1);
        repeat (3) step();
    endtask

    task automatic chk_stats(input string tag, input logic [63:0] w, input logic [63:0] b,
                             input logic [63:0] v, input logic [63:0] a, input logic [63:0] s);
        chk({tag, "_ndone1"}, 64'(n_done1), 64'd1);
        chk({tag, "_ndone3"}, 64'(n_done3), 64'd1);
        chk({tag, "_word1"},  64'(wcnt1), w);
        chk({tag, "_word3"},  64'(wcnt3), w);
        chk({tag, "_bit1"},   64'(bcnt1), b);
        chk({tag, "_bit3"},   64'(bcnt3), b);
        chk({tag, "_fev1"},   64'(fev1), v);
        chk({tag, "_fev3"},   64'(fev3), v);
        chk({tag, "_fea1"},   64'(fea1), a);
        chk({tag, "_fea3"},   64'(fea3), a);
        chk({tag, "_fes1"},   fes1, s);
        chk({tag, "_fes3"},   fes3, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        addr_lo = '0;
        addr_hi = '0;
        sr1     = '0;
        for (int i = 0; i < 3; i++) sr3[i] = '0;
        clear_diffs();
        clear_mon();
        repeat (3) step();

        chk("rst_ren",   64'(r_en1),  64'd0);
        chk("rst_addr",  64'(r_addr1), 64'd0);
        chk("rst_busy",  64'(busy1 | busy3), 64'd0);
        chk("rst_done",  64'(done1 | done3), 64'd0);
        chk("rst_word",  64'(wcnt1), 64'd0);
        chk("rst_bit",   64'(bcnt1), 64'd0);
        chk("rst_fev",   64'(fev1),  64'd0);
        chk("rst_fes",   fes1, 64'd0);
        reset = 1'b0;
        repeat (2) step();

        // Clean sweep 1..3
        sweep(14'd1, 14'd3);
        wait_done("clean");
        chk("clean_nren1", 64'(q1.size()), 64'd3);
        if (q1.size() == 3) begin
            chk("clean_a0", 64'(q1[0]), 64'd1);
            chk("clean_a1", 64'(q1[1]), 64'd2);
            chk("clean_a2", 64'(q1[2]), 64'd3);
        end
        chk("clean_consec", 64'(iss_last1 - iss_first1), 64'd2);
        chk("clean_nren3", 64'(n_ren3), 64'd3);
        chk_stats("clean", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

        // Single-bit fault at address 2
        diff_mem[2] = 64'h4;
        sweep(14'd1, 14'd3);
        wait_done("single");
        chk_stats("single", 64'd1, 64'd1, 64'd1, 64'd2, 64'h4);
        clear_diffs();

        // Two faults: first capture must be the earlier address
        diff_mem[5] = 64'hF;
        diff_mem[6] = 64'h3;
        sweep(14'd4, 14'd7);
        wait_done("multi");
        chk_stats("multi", 64'd2, 64'd6, 64'd1, 64'd5, 64'hF);
        clear_diffs();

        // Top-of-range single read, no wrap
        diff_mem[16383] = 64'h8000_0000_0000_0001;
        sweep(14'd16383, 14'd16383);
        wait_done("top");
        chk("top_nren1", 64'(n_ren1), 64'd1);
        chk("top_nren3", 64'(n_ren3), 64'd1);
        chk("top_lat3",  64'(done_cyc3 - iss_last3), 64'd4);
        chk("top_lat1",  64'(done_cyc1 - iss_last1), 64'd2);
        chk("top_addr1", 64'(r_addr1), 64'd16383);
        chk("top_addr3", 64'(r_addr3), 64'd16383);
        chk_stats("top", 64'd1, 64'd2, 64'd1, 64'd16383, 64'h8000_0000_0000_0001);
        clear_diffs();

        // Empty sweep lo > hi
        sweep(14'd5, 14'd4);
        wait_done("empty");
        chk("empty_nren1", 64'(n_ren1), 64'd0);
        chk("empty_nren3", 64'(n_ren3), 64'd0);
        chk("empty_lat",   64'(done_cyc1 - start_cyc), 64'd1);
        chk_stats("empty", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

        // Start pulse while busy must be ignored
        diff_mem[10] = 64'h8000_0000_0000_0000;
        sweep(14'd8, 14'd12);
        step();
        addr_lo = 14'd0;
        addr_hi = 14'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_done("busy");
        chk("busy_nren1", 64'(q1.size()), 64'd5);
        if (q1.size() == 5) begin
            chk("busy_first", 64'(q1[0]), 64'd8);
            chk("busy_last",  64'(q1[4]), 64'd12);
        end
        chk("busy_nren3", 64'(n_ren3), 64'd5);
        chk_stats("busy", 64'd1, 64'd1, 64'd1, 64'd10, 64'h8000_0000_0000_0000);
        clear_diffs();

        // Reset mid-sweep aborts at once with no done pulse
        diff_mem[0] = 64'h1;
        diff_mem[1] = 64'h1;
        diff_mem[2] = 64'h1;
        sweep(14'd0, 14'd10);
        for (int i = 0; i < 20; i++) begin
            if (r_en1 && r_addr1 == 14'd3) break;
            step();
        end
        chk("abort_reach3", 64'(r_addr1), 64'd3);
        chk("abort_pre_word", 64'(wcnt1), 64'd2);
        reset = 1'b1;
        #1;
        chk("abort_ren1",  64'(r_en1),  64'd0);
        chk("abort_ren3",  64'(r_en3),  64'd0);
        chk("abort_busy",  64'(busy1 | busy3), 64'd0);
        chk("abort_word1", 64'(wcnt1), 64'd0);
        chk("abort_bit1",  64'(bcnt1), 64'd0);
        chk("abort_fev1",  64'(fev1),  64'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();
        chk("abort_ndone1", 64'(n_done1), 64'd0);
        chk("abort_ndone3", 64'(n_done3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_readback_checker.md
Name: mem_readback_checker

Overview:
- Downstream consumer of the 64-bit memory/corruption stage (14-bit R_ADDR, R_EN; outputs real_data and wrong_real_data).
- On start, sweeps a read address range, issues one read per cycle, and aligns the returned data pair to its address through a latency pipeline.
- Compares real_data against wrong_real_data and accumulates word-error and bit-error statistics plus a first-failure capture.
- Sits between the memory stage and the status/readout logic.

Parameters:
DATA_W, 64, width of real_data / wrong_real_data
ADDR_W, 14, width of read address
RD_LAT, 1, cycles from R_EN/R_ADDR to valid data at inputs (legal 1..4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins sweep (ignored while busy)
addr_lo  input  ADDR_W  first address of sweep, sampled on start
addr_hi  input  ADDR_W  last address of sweep (inclusive), sampled on start
R_EN  output  1  read enable to memory stage
R_ADDR  output  ADDR_W  read address to memory stage
real_data  input  DATA_W  golden readback word
wrong_real_data  input  DATA_W  corrupted readback word
busy  output  1  high from cycle after start until done
done  output  1  one-cycle pulse when last compare retires
word_err_cnt  output  ADDR_W+1  words with any differing bit
bit_err_cnt  output  ADDR_W+7  total differing bits over sweep
first_err_valid  output  1  a mismatch has been captured this sweep
first_err_addr  output  ADDR_W  address of first mismatching word
first_err_syn  output  DATA_W  real_data XOR wrong_real_data at first mismatch

Behaviour:
- Reset (async, active-high): state IDLE; R_EN=0, R_ADDR=0, busy=0, done=0, all counters 0, first_err_valid=0, first_err_addr=0, first_err_syn=0, latency pipe valids cleared. Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start, latch lo/hi; if addr_lo > addr_hi go to DONE with zero counts (empty sweep). Otherwise clear counters and first_err_*, go to ISSUE.
- ISSUE: each cycle R_EN=1, R_ADDR=current address; push {valid=1, addr} into RD_LAT-deep shift pipe. When R_ADDR==hi, go to DRAIN next cycle. Address increments modulo 2^ADDR_W; hi=2^ADDR_W-1 terminates without wrap.
- DRAIN: R_EN=0, R_ADDR holds last value; wait until pipe has no valid entries, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. Counters and first_err_* hold until next start.
- busy=1 in ISSUE and DRAIN only.
- Compare: when pipe output valid, diff = real_data XOR wrong_real_data; popcount(diff) (0..64, 7 bits) added to bit_err_cnt; if diff != 0, word_err_cnt += 1; if diff != 0 and first_err_valid==0, capture addr and diff, set first_err_valid.
- Counters saturate at all-ones (no wrap).
- Latency: compare of address A retires RD_LAT cycles after R_ADDR=A with R_EN=1; done asserts 1 cycle after the last compare retires.
- start during busy or DONE ignored.
- Memory stage holds outputs when R_EN=0; checker never samples data without a valid pipe entry.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/DRAIN/DONE), DATA_W/ADDR_W defaults, popcount width constant.
- One sub-module: popcount64 (combinational adder tree, DATA_W in, 7-bit out), reused by other checkers.

Test Plan:
- Reset mid-sweep: assert reset during ISSUE at addr 3 -> R_EN=0, busy=0, counts 0 the same cycle, no done.
- Clean sweep: lo=1, hi=3, no corruption injected -> R_ADDR 1,2,3 on consecutive cycles, done once, word_err_cnt=0, bit_err_cnt=0, first_err_valid=0.
- Single-bit fault: addr 2 corrupted at bit 2 -> word_err_cnt=1, bit_err_cnt=1, first_err_addr=2, first_err_syn=64'h4.
- Multi-fault ordering: addr 5 diff 64'hF, addr 6 diff 64'h3, lo=4, hi=7 -> word_err_cnt=2, bit_err_cnt=6, first_err_addr=5, first_err_syn=64'hF.
- Latency/boundary: RD_LAT=3, lo=hi=16383 -> exactly one read, done 4 cycles after issue, no address wrap; lo=5, hi=4 -> done next cycle, counts 0, R_EN never high.
- Start while busy: pulse start mid-sweep with new lo/hi -> ignored; original range completes unchanged.
